// File: rtl/pixel_row_deserializer.sv
// Serial-to-parallel pixel collector: packs NUM_PIXELS consecutive pixels
// into one row, with valid/ready on both sides, a one-row holding buffer,
// optional JPEG level shift and flush-by-edge-replication of partial rows.
module pixel_row_deserializer #(
    parameter int WIDTH       = 8,
    parameter int NUM_PIXELS  = 8,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [WIDTH-1:0]            Data_In,
    input  logic                        En_In,
    output logic                        Ready_Out,
    input  logic                        Flush,
    output logic [NUM_PIXELS*WIDTH-1:0] Data_Out,
    output logic                        En_Out,
    input  logic                        Ready_In,
    output logic                        Padded
);

    localparam int CW    = $clog2(NUM_PIXELS);
    localparam int ROW_W = NUM_PIXELS * WIDTH;
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_PIXELS - 1);

    typedef enum logic {
        FILL,
        FULL
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     counter;
    logic [ROW_W-1:0]  fill_buf;
    logic              pend_padded;

    logic [WIDTH-1:0]  shifted_pixel;
    logic [WIDTH-1:0]  last_val;
    logic [ROW_W-1:0]  next_row;
    int                last_idx;
    logic              accept;
    logic              last_accept;
    logic              row_done;
    logic              row_padded;
    logic              out_free;
    logic              load_new;
    logic              load_held;

    // Upstream may only push while the fill buffer is not holding a finished row.
    assign Ready_Out   = (state == FILL);
    assign accept      = En_In & Ready_Out;
    assign last_accept = accept & (counter == LAST_SLOT);
    assign row_done    = last_accept | (Ready_Out & Flush & (accept | (counter != '0)));
    assign row_padded  = row_done & ~last_accept;
    assign out_free    = ~En_Out | Ready_In;

    // Level shift turns unsigned samples into signed ones by flipping the MSB.
    always_comb begin
        shifted_pixel = Data_In;
        if (LEVEL_SHIFT != 0) begin
            shifted_pixel[WIDTH-1] = ~Data_In[WIDTH-1];
        end
    end

    // Build the row as it will look after this cycle's accept and/or flush replication.
    always_comb begin
        last_idx = accept ? int'(counter) : int'(counter) - 1;
        last_val = shifted_pixel;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            if (!accept && i == last_idx) begin
                last_val = fill_buf[i*WIDTH +: WIDTH];
            end
        end
        next_row = fill_buf;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            if (accept && i == int'(counter)) begin
                next_row[i*WIDTH +: WIDTH] = shifted_pixel;
            end else if (row_padded && i > last_idx) begin
                next_row[i*WIDTH +: WIDTH] = last_val;
            end
        end
    end

    // FILL/FULL decision: hand a finished row straight out, or park it until the output drains.
    always_comb begin
        state_next = state;
        load_new   = 1'b0;
        load_held  = 1'b0;
        case (state)
            FILL: begin
                if (row_done) begin
                    if (out_free) begin
                        load_new = 1'b1;
                    end else begin
                        state_next = FULL;
                    end
                end
            end
            FULL: begin
                if (En_Out && Ready_In) begin
                    load_held  = 1'b1;
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Fill buffer, slot counter and output register updates.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            counter     <= '0;
            fill_buf    <= '0;
            pend_padded <= 1'b0;
            Data_Out    <= '0;
            En_Out      <= 1'b0;
            Padded      <= 1'b0;
        end else begin
            if (accept || row_done) begin
                fill_buf <= next_row;
            end
            if (row_done) begin
                counter     <= '0;
                pend_padded <= row_padded;
            end else if (accept) begin
                counter <= counter + CW'(1);
            end
            if (load_new) begin
                Data_Out <= next_row;
                Padded   <= row_padded;
                En_Out   <= 1'b1;
            end else if (load_held) begin
                Data_Out <= fill_buf;
                Padded   <= pend_padded;
                En_Out   <= 1'b1;
            end else if (En_Out && Ready_In) begin
                En_Out <= 1'b0;
            end
        end
    end

endmodule
